// File: rtl/frame_buffer_pingpong.sv
// frame_buffer_pingpong: two-bank pixel store; host fills the back bank, panel reads the front bank.
// Banks swap only on frame_done; `define FB_CLEAR_EN builds the back-bank clear engine.
module frame_buffer_pingpong #(
    parameter int             WIDTH       = 128,
    parameter int             HEIGHT      = 64,
    parameter int             CHAINED     = 1,
    parameter int             BPP         = 12,
    parameter logic [BPP-1:0] CLEAR_VALUE = '0,
    parameter int             AW          = $clog2(CHAINED * WIDTH * HEIGHT)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           wr_en_i,
    input  logic [AW-1:0]  wr_addr_i,
    input  logic [BPP-1:0] wr_data_i,
    output logic           wr_ready_o,
    input  logic           rd_en_i,
    input  logic [AW-1:0]  rd_addr_i,
    output logic [BPP-1:0] rd_data_o,
    output logic           rd_valid_o,
    input  logic           swap_req_i,
    input  logic           frame_done_i,
    output logic           swap_pending_o,
    output logic           front_sel_o,
    input  logic           clear_req_i,
    output logic           clear_busy_o
);
    localparam int DEPTH = CHAINED * WIDTH * HEIGHT;
    localparam int IW = $clog2(DEPTH);
    // AW may be wider than IW, so range checks compare against the full pixel count
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [BPP-1:0] mem_q [2][DEPTH];
    logic           front_q, front_d, pend_q, pend_d, valid_q, do_swap;
    logic [BPP-1:0] rd_data_q, rd_data_d, wdata;
    logic [IW-1:0]  clr_addr, waddr;
    logic           busy, we;

`ifdef FB_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] clr_q, clr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = '0;
        if (state_q == IDLE) begin
            if (clear_req_i) state_d = CLEAR;
        end else begin
            clr_d = clr_q + 1'b1;
            if (clr_q == IW'(DEPTH - 1)) state_d = IDLE;
        end
    end

    assign busy     = state_q == CLEAR;
    assign clr_addr = clr_q;
`else
    logic unused_clear_req;
    assign unused_clear_req = clear_req_i;
    assign busy     = 1'b0;
    assign clr_addr = '0;
`endif

    // the clear engine owns the back-bank write port while busy; host writes are dropped then
    assign we    = busy | (wr_en_i & ({1'b0, wr_addr_i} < DEPTH_W));
    assign waddr = busy ? clr_addr : wr_addr_i[IW-1:0];
    assign wdata = busy ? CLEAR_VALUE : wr_data_i;

    always_ff @(posedge clk_i) begin
        if (we) mem_q[~front_q][waddr] <= wdata;
    end

    always_comb begin
        do_swap   = frame_done_i & (pend_q | swap_req_i) & ~busy;
        front_d   = front_q ^ do_swap;
        pend_d    = ~do_swap & (pend_q | swap_req_i);
        rd_data_d = rd_data_q;
        if (rd_en_i)
            rd_data_d = ({1'b0, rd_addr_i} < DEPTH_W) ? mem_q[front_q][rd_addr_i[IW-1:0]] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            front_q   <= 1'b0;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
            rd_data_q <= '0;
        end else begin
            front_q   <= front_d;
            pend_q    <= pend_d;
            valid_q   <= rd_en_i;
            rd_data_q <= rd_data_d;
        end
    end

    assign wr_ready_o     = ~busy;
    assign clear_busy_o   = busy;
    assign rd_data_o      = rd_data_q;
    assign rd_valid_o     = valid_q;
    assign swap_pending_o = pend_q;
    assign front_sel_o    = front_q;
endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// tb_frame_buffer_pingpong: directed stimulus, per-cycle compare against a bank-level model.
module tb_frame_buffer_pingpong;
    localparam int D = 32;
    localparam int AW = 6;
    localparam logic [11:0] CV = 12'h5A5;

    logic clk = 0, rst_n = 0;
    logic wr_en = 0, rd_en = 0, swap_req = 0, frame_done = 0, clear_req = 0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [11:0] wr_data = '0;
    logic [11:0] rd_data;
    logic rd_valid, wr_ready, swap_pending, front_sel, clear_busy;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    frame_buffer_pingpong #(.WIDTH(8), .HEIGHT(4), .CHAINED(1), .BPP(12),
                            .CLEAR_VALUE(CV), .AW(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .swap_req_i(swap_req), .frame_done_i(frame_done),
        .swap_pending_o(swap_pending), .front_sel_o(front_sel),
        .clear_req_i(clear_req), .clear_busy_o(clear_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // bank model: a clear fills the whole back bank at once, since nothing can read it until a swap
    logic [11:0] mm [2][D];
    bit          mk [2][D];
    bit          m_front, m_pend, m_valid, m_known, m_busy;
    logic [11:0] m_data;
    int          busy_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_front = 0; m_pend = 0; m_valid = 0; m_known = 1; m_data = '0; busy_left = 0;
            foreach (mk[b, i]) mk[b][i] = 0;
        end else begin
            m_busy = busy_left > 0;
            m_valid = rd_en;
            if (rd_en) begin
                if (rd_addr < D) begin
                    m_data = mm[m_front][rd_addr]; m_known = mk[m_front][rd_addr];
                end else begin
                    m_data = '0; m_known = 1;
                end
            end
            if (wr_en && !m_busy && wr_addr < D) begin
                mm[!m_front][wr_addr] = wr_data; mk[!m_front][wr_addr] = 1;
            end
            if (frame_done && (m_pend || swap_req) && !m_busy) begin
                m_front = !m_front; m_pend = 0;
            end else m_pend = m_pend || swap_req;
            if (m_busy) busy_left--;
`ifdef FB_CLEAR_EN
            else if (clear_req) begin
                busy_left = D;
                for (int i = 0; i < D; i++) begin
                    mm[!m_front][i] = CV; mk[!m_front][i] = 1;
                end
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("front_sel", front_sel, m_front);
            chk("swap_pending", swap_pending, m_pend);
            chk("rd_valid", rd_valid, m_valid);
            if (m_known) chk("rd_data", rd_data, m_data);
            chk("wr_ready", wr_ready, busy_left == 0);
            chk("clear_busy", clear_busy, busy_left > 0);
        end
    end

    function automatic logic [11:0] pat(input int i, input int seed);
        return 12'(i * 37 + seed);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [11:0] d);
        wr_en = 1; wr_addr = AW'(a); wr_data = d;
        tick;
        wr_en = 0;
    endtask

    task automatic rd(input int a);
        rd_en = 1; rd_addr = AW'(a);
        tick;
        rd_en = 0;
    endtask

    task automatic fill(input int seed);
        for (int i = 0; i < D; i++) wr(i, pat(i, seed));
    endtask

    task automatic swap_now;
        swap_req = 1; frame_done = 1;
        tick;
        swap_req = 0; frame_done = 0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_front", front_sel, 0);
        chk("rst_pending", swap_pending, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ready", wr_ready, 1);

        wr(5, 12'hABC);
        rd(5);
        chk("first_rd_valid", rd_valid, 1);
        chk("abc_hidden", rd_data == 12'hABC, 0);

        swap_req = 1; tick; swap_req = 0;
        for (int k = 0; k < 10; k++) begin
            chk("pending_hold", swap_pending, 1);
            tick;
        end
        frame_done = 1; tick; frame_done = 0;
        chk("swap_front", front_sel, 1);
        chk("swap_pend_clr", swap_pending, 0);
        rd(5);
        chk("abc_visible", rd_data, 12'hABC);
        chk("abc_valid", rd_valid, 1);

        swap_now;
        chk("simul_front", front_sel, 0);
        chk("simul_pend", swap_pending, 0);

        swap_req = 1; tick; swap_req = 0;
        frame_done = 1; tick; frame_done = 0;
        chk("one_toggle_a", front_sel, 1);
        tick;
        frame_done = 1; tick; frame_done = 0;
        chk("one_toggle_b", front_sel, 1);

        wr(31, 12'h123); wr(0, 12'h123); wr(8, 12'h055); wr(40, 12'h777);
        swap_now;
        chk("range_front", front_sel, 0);
        rd(31); chk("addr31", rd_data, 12'h123);
        rd(0);  chk("addr0", rd_data, 12'h123);
        rd(8);  chk("alias_drop", rd_data, 12'h055);
        rd(40); chk("oor_data", rd_data, 0); chk("oor_valid", rd_valid, 1);
        rd(63); chk("oor_top", rd_data, 0);

        fill(11);
        swap_now;
        rd_en = 1;
        for (int i = 0; i < D; i++) begin
            rd_addr = AW'(i);
            tick;
            chk("stream_valid", rd_valid, 1);
            chk("stream_data", rd_data, pat(i, 11));
        end
        rd_en = 0;
        tick;
        chk("stream_stop", rd_valid, 0);
        chk("stream_hold", rd_data, pat(31, 11));

`ifdef FB_CLEAR_EN
        fill(3);
        clear_req = 1; tick; clear_req = 0;
        chk("clr_busy_start", clear_busy, 1);
        chk("clr_ready_low", wr_ready, 0);
        n = 0;
        while (clear_busy && n < 100) begin
            wr_en = (n == 3); wr_addr = 6'd3; wr_data = 12'h999;
            swap_req = (n == 5); frame_done = (n == 10); clear_req = (n == 7);
            tick;
            n++;
        end
        wr_en = 0; swap_req = 0; frame_done = 0; clear_req = 0;
        chk("clear_len", n, D);
        chk("clr_no_swap", front_sel, 1);
        chk("clr_pend_hold", swap_pending, 1);
        frame_done = 1; tick; frame_done = 0;
        chk("clr_swap", front_sel, 0);
        rd_en = 1;
        for (int i = 0; i < D; i++) begin
            rd_addr = AW'(i);
            tick;
            chk("clear_value", rd_data, CV);
        end
        rd_en = 0;
`else
        clear_req = 1; tick; clear_req = 0;
        chk("noclr_busy", clear_busy, 0);
        chk("noclr_ready", wr_ready, 1);
`endif

        swap_req = 1; clear_req = 1; tick; swap_req = 0; clear_req = 0;
        rd_en = 1; rd_addr = 6'd1; tick; rd_en = 0;
        chk("pre_rst_pend", swap_pending, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_front", front_sel, 0);
        chk("arst_pend", swap_pending, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_busy", clear_busy, 0);
        chk("arst_ready", wr_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
